// File: rtl/rf_wb_arbiter_pkg.sv
// rf_wb_arbiter_pkg: shared widths, load FIFO depth and the write-back request type
package rf_wb_arbiter_pkg;
    localparam int XLEN = 32;
    localparam int NB_REGS = 5;
    localparam int LSU_WB_DEPTH = 4;
    typedef struct packed {
        logic [NB_REGS-1:0] adr;
        logic [XLEN-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/rf_wb_arbiter_wb_fifo.sv
// wb_fifo: power-of-two write-back request FIFO with occupancy count
module wb_fifo
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = LSU_WB_DEPTH,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  wb_req_t       din,
    output wb_req_t       dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    wb_req_t mem [DEPTH];
    logic [AW-1:0] wp, rp;
    assign dout = mem[rp];
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    // pointers wrap naturally; storage needs no reset because count gates every read
    always_ff @(posedge clk) begin
        if (reset) begin
            wp <= '0;
            rp <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wp] <= din;
                wp <= wp + AW'(1);
            end
            if (pop) rp <= rp + AW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: merges exec and buffered load results into one registered rf write port (optional bypass: RF_BYPASS_EN)
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int LSU_DEPTH = LSU_WB_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exe_valid_i,
    output logic                         exe_ready_o,
    input  logic [NB_REGS-1:0]           exe_adr_i,
    input  logic [XLEN-1:0]              exe_data_i,
    input  logic                         lsu_valid_i,
    output logic                         lsu_ready_o,
    input  logic [NB_REGS-1:0]           lsu_adr_i,
    input  logic [XLEN-1:0]              lsu_data_i,
    output logic                         write_valid_o,
    output logic [NB_REGS-1:0]           write_adr_o,
    output logic [XLEN-1:0]              write_data_o,
    output logic [$clog2(LSU_DEPTH):0]   lsu_count_o
`ifdef RF_BYPASS_EN
    ,
    input  logic [NB_REGS-1:0]           byp_rs1_adr_i,
    input  logic [NB_REGS-1:0]           byp_rs2_adr_i,
    output logic                         byp_rs1_hit_o,
    output logic                         byp_rs2_hit_o,
    output logic [XLEN-1:0]              byp_rs1_data_o,
    output logic [XLEN-1:0]              byp_rs2_data_o
`endif
);
    wb_req_t head, sel;
    logic full, empty, exe_grant, lsu_grant, wr;
    assign exe_ready_o = ~reset & ~full;
    assign exe_grant = exe_valid_i & exe_ready_o;
    assign lsu_grant = ~reset & ~empty & (full | ~exe_valid_i);
    assign lsu_ready_o = ~reset & (~full | lsu_grant);
    assign sel = exe_grant ? {exe_adr_i, exe_data_i} : head;
    assign wr = (exe_grant | lsu_grant) & (|sel.adr);
    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (lsu_valid_i & lsu_ready_o),
        .pop   (lsu_grant),
        .din   ({lsu_adr_i, lsu_data_i}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (lsu_count_o)
    );
    // commit register: x0 grants are consumed without a write, adr/data hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            write_valid_o <= 1'b0;
            write_adr_o <= '0;
            write_data_o <= '0;
        end else begin
            write_valid_o <= wr;
            if (wr) begin
                write_adr_o <= sel.adr;
                write_data_o <= sel.data;
            end
        end
    end
`ifdef RF_BYPASS_EN
    assign byp_rs1_hit_o = write_valid_o & (write_adr_o == byp_rs1_adr_i);
    assign byp_rs2_hit_o = write_valid_o & (write_adr_o == byp_rs2_adr_i);
    assign byp_rs1_data_o = byp_rs1_hit_o ? write_data_o : '0;
    assign byp_rs2_data_o = byp_rs2_hit_o ? write_data_o : '0;
`endif
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb_rf_wb_arbiter: table vectors plus scoreboard of expected rf writes
module tb_rf_wb_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic exe_valid_i = 1'b0, lsu_valid_i = 1'b0;
    logic [4:0] exe_adr_i = '0, lsu_adr_i = '0;
    logic [31:0] exe_data_i = '0, lsu_data_i = '0;
    logic exe_ready_o, lsu_ready_o, write_valid_o;
    logic [4:0] write_adr_o;
    logic [31:0] write_data_o;
    logic [2:0] lsu_count_o;
`ifdef RF_BYPASS_EN
    logic [4:0] byp_rs1_adr_i = '0, byp_rs2_adr_i = '0;
    logic byp_rs1_hit_o, byp_rs2_hit_o;
    logic [31:0] byp_rs1_data_o, byp_rs2_data_o;
`endif

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .exe_valid_i   (exe_valid_i),
        .exe_ready_o   (exe_ready_o),
        .exe_adr_i     (exe_adr_i),
        .exe_data_i    (exe_data_i),
        .lsu_valid_i   (lsu_valid_i),
        .lsu_ready_o   (lsu_ready_o),
        .lsu_adr_i     (lsu_adr_i),
        .lsu_data_i    (lsu_data_i),
        .write_valid_o (write_valid_o),
        .write_adr_o   (write_adr_o),
        .write_data_o  (write_data_o),
        .lsu_count_o   (lsu_count_o)
`ifdef RF_BYPASS_EN
        ,
        .byp_rs1_adr_i (byp_rs1_adr_i),
        .byp_rs2_adr_i (byp_rs2_adr_i),
        .byp_rs1_hit_o (byp_rs1_hit_o),
        .byp_rs2_hit_o (byp_rs2_hit_o),
        .byp_rs1_data_o(byp_rs1_data_o),
        .byp_rs2_data_o(byp_rs2_data_o)
`endif
    );

    typedef struct {
        bit ev; bit [4:0] ea; bit [31:0] ed;
        bit lv; bit [4:0] la; bit [31:0] ld;
        bit er; int cnt;
    } vec_t;
    typedef struct {bit [4:0] a; bit [31:0] d;} rq_t;
    typedef struct {bit v; bit [4:0] a; bit [31:0] d;} wr_t;

    rq_t mq[$];
    wr_t sb[$];
    bit [4:0] last_a;
    bit [31:0] last_d;
    logic last_er, last_lr;
    int n_chk = 0, n_fail = 0;
    vec_t tv [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit ev, input bit [4:0] ea, input bit [31:0] ed,
                        input bit lv, input bit [4:0] la, input bit [31:0] ld);
        bit full, er, lr, eg, fg, gv;
        rq_t g;
        wr_t w;
        reset = r;
        exe_valid_i = ev; exe_adr_i = ea; exe_data_i = ed;
        lsu_valid_i = lv; lsu_adr_i = la; lsu_data_i = ld;
        #1;
        full = mq.size() == 4;
        er = !r && !full;
        fg = !r && mq.size() != 0 && (full || !ev);
        lr = !r && (!full || fg);
        eg = ev && er;
        chk("exe_ready", exe_ready_o, er);
        chk("lsu_ready", lsu_ready_o, lr);
        last_er = exe_ready_o;
        last_lr = lsu_ready_o;
        gv = eg || fg;
        g = '{5'd0, 32'd0};
        if (eg) g = '{ea, ed};
        else if (fg) g = mq.pop_front();
        if (lv && lr) mq.push_back('{la, ld});
        if (r) begin
            mq.delete();
            last_a = '0;
            last_d = '0;
            w = '{1'b0, 5'd0, 32'd0};
        end else begin
            if (gv && g.a != 0) begin
                last_a = g.a;
                last_d = g.d;
            end
            w = '{gv && g.a != 0, last_a, last_d};
        end
        sb.push_back(w);
        @(posedge clk);
        #1;
        w = sb.pop_front();
        chk("write_valid", write_valid_o, w.v);
        chk("write_adr", write_adr_o, w.a);
        chk("write_data", write_data_o, w.d);
        chk("lsu_count", lsu_count_o, mq.size());
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        tv[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b1, 0};
        tv[1] = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b1, 1};
        tv[2] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 0};
        tv[3] = '{1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'h0, 1'b1, 0};
        tv[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hAB, 1'b1, 1};
        tv[5] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 0};
        tv[6] = '{1'b1, 5'd1, 32'h1, 1'b1, 5'd9, 32'h99, 1'b1, 1};
        tv[7] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 0};
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2);
        chk("reset_valid", write_valid_o, 1'b0);
        chk("reset_count", lsu_count_o, 3'd0);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tv[i].ev, tv[i].ea, tv[i].ed, tv[i].lv, tv[i].la, tv[i].ld);
            chk("tbl_exe_ready", last_er, tv[i].er);
            chk("tbl_count", lsu_count_o, tv[i].cnt);
        end
        for (int k = 0; k < 4; k++)
            step(1'b0, 1'b1, 5'(12 + k), 32'h100 + k, 1'b1, 5'(8 + k), 32'h200 + k);
        chk("full_count", lsu_count_o, 3'd4);
        step(1'b0, 1'b1, 5'd16, 32'h300, 1'b1, 5'd17, 32'h400);
        chk("full_exe_ready", last_er, 1'b0);
        chk("full_lsu_ready", last_lr, 1'b1);
        chk("full_push_pop_count", lsu_count_o, 3'd4);
        chk("full_head_adr", write_adr_o, 5'd8);
        step(1'b0, 1'b1, 5'd16, 32'h300, 1'b0, 5'd0, 32'h0);
        chk("drain_adr", write_adr_o, 5'd9);
        step(1'b0, 1'b1, 5'd16, 32'h300, 1'b0, 5'd0, 32'h0);
        chk("exec_after_full", write_adr_o, 5'd16);
        for (int k = 0; k < 4; k++) idle();
        step(1'b0, 1'b1, 5'd20, 32'h5, 1'b1, 5'd21, 32'h6);
        step(1'b0, 1'b1, 5'd22, 32'h7, 1'b1, 5'd23, 32'h8);
        step(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        chk("midreset_valid", write_valid_o, 1'b0);
        chk("midreset_count", lsu_count_o, 3'd0);
        idle();
        chk("after_reset_valid", write_valid_o, 1'b0);
`ifdef RF_BYPASS_EN
        step(1'b0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0, 32'h0);
        byp_rs1_adr_i = 5'd7;
        byp_rs2_adr_i = 5'd6;
        #1;
        chk("byp_rs1_hit", byp_rs1_hit_o, 1'b1);
        chk("byp_rs1_data", byp_rs1_data_o, 32'h1234);
        chk("byp_rs2_hit", byp_rs2_hit_o, 1'b0);
        chk("byp_rs2_data", byp_rs2_data_o, 32'h0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
